// File: rtl/itch_parser_mc.sv
// itch_parser_mc: NUM_CH byte-serial ITCH feeds, each parsed, held, round-robin merged into one FWFT record FIFO
//   clk, rst (async, active-low)
//   valid_in[NUM_CH], byte_in[NUM_CH*8]  : per-channel byte strobe and byte (channel c at [8c+7:8c])
//   out_valid/out_ready                  : FIFO head handshake, pop on out_valid && out_ready
//   out_ch, out_type, out_order_ref, out_side, out_shares, out_price,
//   out_new_ref, out_timestamp, out_misc : head record fields, all zero while out_valid=0
//   fifo_level                           : FIFO occupancy 0..FIFO_DEPTH
//   drop_cnt[NUM_CH*DROP_CNT_W]          : per-channel saturating overrun counters
//
// parser: single-stream ITCH 5.0 subset decoder (async active-high rst)
//   Type byte selects length; unknown type bytes are skipped one at a time.
//   parsed_type: 1=A add, 2=D delete, 3=X cancel, 4=E executed, 5=U replace.
//   side=1 for 'S'. misc_data carries the stock symbol (A) or match number (E).
//   parsed_valid pulses for one cycle after the last byte; fields hold until the next type byte.
module parser (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [7:0]  byte_in,
  output logic        parsed_valid,
  output logic [3:0]  parsed_type,
  output logic [63:0] order_ref,
  output logic        side,
  output logic [31:0] shares,
  output logic [31:0] price,
  output logic [63:0] new_order_ref,
  output logic [47:0] timestamp,
  output logic [63:0] misc_data
);
  typedef enum logic {IDLE, BODY} state_t;
  state_t state, state_nx;
  logic [5:0] pos, last, last_nx;
  logic [3:0] code;
  logic start, done, body;
  logic is_a, is_x, is_e, is_u;
  logic ld_ts, ld_ref, ld_side, ld_shares, ld_price, ld_nref, ld_misc;
  function automatic logic in_range(input logic [5:0] p, input int lo, input int hi);
    return int'(p) >= lo && int'(p) <= hi;
  endfunction
  always_comb begin
    code = byte_in == "A" ? 4'd1 : byte_in == "D" ? 4'd2 : byte_in == "X" ? 4'd3 :
           byte_in == "E" ? 4'd4 : byte_in == "U" ? 4'd5 : 4'd0;
    last_nx = code == 4'd1 ? 6'd35 : code == 4'd2 ? 6'd18 : code == 4'd3 ? 6'd22 :
              code == 4'd4 ? 6'd30 : 6'd34;
  end
  always_comb begin
    state_nx = state;
    start = 1'b0;
    done = 1'b0;
    if (valid_in && state == IDLE && code != 4'd0) begin
      state_nx = BODY;
      start = 1'b1;
    end
    if (valid_in && state == BODY && pos == last) begin
      state_nx = IDLE;
      done = 1'b1;
    end
  end
  assign body = valid_in && state == BODY;
  assign is_a = parsed_type == 4'd1;
  assign is_x = parsed_type == 4'd3;
  assign is_e = parsed_type == 4'd4;
  assign is_u = parsed_type == 4'd5;
  // Byte offsets follow the ITCH 5.0 layouts; all multi-byte fields are big-endian.
  assign ld_ts     = body && in_range(pos, 5, 10);
  assign ld_ref    = body && in_range(pos, 11, 18);
  assign ld_side   = body && is_a && pos == 6'd19;
  assign ld_shares = body && (is_a ? in_range(pos, 20, 23) : (is_x || is_e) ? in_range(pos, 19, 22) :
                              is_u && in_range(pos, 27, 30));
  assign ld_price  = body && (is_a ? in_range(pos, 32, 35) : is_u && in_range(pos, 31, 34));
  assign ld_nref   = body && is_u && in_range(pos, 19, 26);
  assign ld_misc   = body && (is_a ? in_range(pos, 24, 31) : is_e && in_range(pos, 23, 30));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      last <= '0;
      parsed_valid <= 1'b0;
      parsed_type <= '0;
      order_ref <= '0;
      side <= 1'b0;
      shares <= '0;
      price <= '0;
      new_order_ref <= '0;
      timestamp <= '0;
      misc_data <= '0;
    end else begin
      state <= state_nx;
      parsed_valid <= done;
      pos <= start ? 6'd1 : body ? pos + 6'd1 : pos;
      if (start) begin
        parsed_type <= code;
        last <= last_nx;
        order_ref <= '0;
        side <= 1'b0;
        shares <= '0;
        price <= '0;
        new_order_ref <= '0;
        timestamp <= '0;
        misc_data <= '0;
      end
      if (ld_ts) timestamp <= {timestamp[39:0], byte_in};
      if (ld_ref) order_ref <= {order_ref[55:0], byte_in};
      if (ld_side) side <= byte_in == "S";
      if (ld_shares) shares <= {shares[23:0], byte_in};
      if (ld_price) price <= {price[23:0], byte_in};
      if (ld_nref) new_order_ref <= {new_order_ref[55:0], byte_in};
      if (ld_misc) misc_data <= {misc_data[55:0], byte_in};
    end
endmodule

module itch_parser_mc #(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          valid_in,
  input  logic [NUM_CH*8-1:0]        byte_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_ch,
  output logic [3:0]                 out_type,
  output logic [63:0]                out_order_ref,
  output logic                       out_side,
  output logic [31:0]                out_shares,
  output logic [31:0]                out_price,
  output logic [63:0]                out_new_ref,
  output logic [47:0]                out_timestamp,
  output logic [63:0]                out_misc,
  output logic [AW:0]                fifo_level,
  output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
);
  localparam int REC_W = 4 + 64 + 1 + 32 + 32 + 64 + 48 + 64;
  localparam int ENT_W = CH_W + REC_W;
  logic [NUM_CH-1:0] pv, hold_v, gnt, load;
  logic [REC_W-1:0] rec [NUM_CH];
  logic [REC_W-1:0] hold_rec [NUM_CH];
  logic [DROP_CNT_W-1:0] drops [NUM_CH];
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic [CH_W-1:0] rr, gnt_ch, ch_lo, ch_hi;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic gnt_any, gnt_lo, gnt_hi, can_push, pop;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [3:0] p_type;
      logic [63:0] p_ref, p_nref, p_misc;
      logic p_side;
      logic [31:0] p_shares, p_price;
      logic [47:0] p_ts;
      parser u_parser (
        .clk(clk),
        .rst(~rst),
        .valid_in(valid_in[c]),
        .byte_in(byte_in[8*c +: 8]),
        .parsed_valid(pv[c]),
        .parsed_type(p_type),
        .order_ref(p_ref),
        .side(p_side),
        .shares(p_shares),
        .price(p_price),
        .new_order_ref(p_nref),
        .timestamp(p_ts),
        .misc_data(p_misc)
      );
      assign rec[c] = {p_type, p_ref, p_side, p_shares, p_price, p_nref, p_ts, p_misc};
      assign drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = drops[c];
    end
  endgenerate
  assign out_valid = fifo_level != '0;
  assign pop = out_valid && out_ready;
  // A pop on a full FIFO frees the slot in the same cycle, so grant is still allowed.
  assign can_push = fifo_level != (AW+1)'(FIFO_DEPTH) || pop;
  // Round robin: prefer the lowest requester above rr, else wrap to the lowest at or below rr.
  always_comb begin
    gnt_lo = 1'b0;
    gnt_hi = 1'b0;
    ch_lo = '0;
    ch_hi = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hold_v[i] && CH_W'(i) > rr) begin
        gnt_hi = 1'b1;
        ch_hi = CH_W'(i);
      end
      if (hold_v[i] && CH_W'(i) <= rr) begin
        gnt_lo = 1'b1;
        ch_lo = CH_W'(i);
      end
    end
    gnt_any = can_push && (gnt_hi || gnt_lo);
    gnt_ch = gnt_hi ? ch_hi : ch_lo;
    gnt = gnt_any ? NUM_CH'(1) << gnt_ch : '0;
  end
  // A granted slot can reload from the parser on the same edge, so no drop in that case.
  assign load = pv & (~hold_v | gnt);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold_v <= '0;
      rr <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) drops[i] <= '0;
    end else begin
      hold_v <= pv | (hold_v & ~gnt);
      if (gnt_any) rr <= gnt_ch;
      for (int i = 0; i < NUM_CH; i++)
        if (pv[i] && hold_v[i] && !gnt[i] && drops[i] != '1) drops[i] <= drops[i] + 1'b1;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (load[i]) hold_rec[i] <= rec[i];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(gnt_any);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(gnt_any) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (gnt_any) mem[wr_ptr] <= {gnt_ch, hold_rec[gnt_ch]};
  assign head = out_valid ? mem[rd_ptr] : '0;
  assign {out_ch, out_type, out_order_ref, out_side, out_shares, out_price,
          out_new_ref, out_timestamp, out_misc} = head;
endmodule

// File: tb/tb_itch_parser_mc.sv
// tb_itch_parser_mc: directed bench for itch_parser_mc (4 channels, depth 8, 4-bit drop counters)
module tb_itch_parser_mc;
  localparam int NC = 4;
  localparam int D = 8;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0] valid_in = '0;
  logic [NC*8-1:0] byte_in = '0;
  logic out_ready = 1'b0;
  logic out_valid, out_side;
  logic [1:0] out_ch;
  logic [3:0] out_type;
  logic [63:0] out_order_ref, out_new_ref, out_misc;
  logic [31:0] out_shares, out_price;
  logic [47:0] out_timestamp;
  logic [3:0] fifo_level;
  logic [NC*DW-1:0] drop_cnt;
  logic [7:0] mb [NC][40];
  int ml [NC];
  int ord [4] = '{2, 3, 0, 1};
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  itch_parser_mc #(.NUM_CH(NC), .FIFO_DEPTH(D), .DROP_CNT_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .byte_in(byte_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch(out_ch),
    .out_type(out_type),
    .out_order_ref(out_order_ref),
    .out_side(out_side),
    .out_shares(out_shares),
    .out_price(out_price),
    .out_new_ref(out_new_ref),
    .out_timestamp(out_timestamp),
    .out_misc(out_misc),
    .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, got, exp);
    end
  endtask
  task automatic chk_rec(input string t, input int ch, input logic [3:0] ty, input logic [63:0] oref,
                         input logic sd, input logic [31:0] sh, input logic [31:0] pr,
                         input logic [63:0] nref, input logic [47:0] ts, input logic [63:0] misc);
    chk({t, ".valid"}, 64'(out_valid), 64'd1);
    chk({t, ".ch"}, 64'(out_ch), 64'(ch));
    chk({t, ".type"}, 64'(out_type), 64'(ty));
    chk({t, ".ref"}, out_order_ref, oref);
    chk({t, ".side"}, 64'(out_side), 64'(sd));
    chk({t, ".shares"}, 64'(out_shares), 64'(sh));
    chk({t, ".price"}, 64'(out_price), 64'(pr));
    chk({t, ".nref"}, out_new_ref, nref);
    chk({t, ".ts"}, 64'(out_timestamp), 64'(ts));
    chk({t, ".misc"}, out_misc, misc);
  endtask
  task automatic put(input int ch, input int p, input int nb, input logic [63:0] v);
    for (int i = 0; i < nb; i++) mb[ch][p+i] = v[8*(nb-1-i) +: 8];
  endtask
  task automatic mk_hdr(input int ch, input logic [7:0] t, input int len, input logic [47:0] ts);
    mb[ch][0] = t;
    put(ch, 1, 2, 64'h0001);
    put(ch, 3, 2, 64'h0000);
    put(ch, 5, 6, 64'(ts));
    ml[ch] = len;
  endtask
  task automatic mk_add(input int ch, input logic [47:0] ts, input logic [63:0] oref, input logic [7:0] sd,
                        input logic [31:0] sh, input logic [63:0] stock, input logic [31:0] pr);
    mk_hdr(ch, "A", 36, ts);
    put(ch, 11, 8, oref);
    mb[ch][19] = sd;
    put(ch, 20, 4, 64'(sh));
    put(ch, 24, 8, stock);
    put(ch, 32, 4, 64'(pr));
  endtask
  task automatic mk_del(input int ch, input logic [47:0] ts, input logic [63:0] oref);
    mk_hdr(ch, "D", 19, ts);
    put(ch, 11, 8, oref);
  endtask
  task automatic mk_exe(input int ch, input logic [47:0] ts, input logic [63:0] oref,
                        input logic [31:0] sh, input logic [63:0] mt);
    mk_hdr(ch, "E", 31, ts);
    put(ch, 11, 8, oref);
    put(ch, 19, 4, 64'(sh));
    put(ch, 23, 8, mt);
  endtask
  task automatic mk_rep(input int ch, input logic [47:0] ts, input logic [63:0] oref, input logic [63:0] nref,
                        input logic [31:0] sh, input logic [31:0] pr);
    mk_hdr(ch, "U", 35, ts);
    put(ch, 11, 8, oref);
    put(ch, 19, 8, nref);
    put(ch, 27, 4, 64'(sh));
    put(ch, 31, 4, 64'(pr));
  endtask
  task automatic play(input logic [NC-1:0] m);
    int n = 0;
    for (int c = 0; c < NC; c++) if (m[c] && ml[c] > n) n = ml[c];
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NC; c++) begin
        valid_in[c] = m[c] && i < ml[c];
        byte_in[8*c +: 8] = (m[c] && i < ml[c]) ? mb[c][i] : 8'h00;
      end
      tick();
    end
    valid_in = '0;
  endtask
  task automatic pop1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic pulse_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #2 rst = 1'b0;
    tick();
    tick();
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.level", 64'(fifo_level), 64'd0);
    chk("reset.drop", 64'(drop_cnt), 64'd0);
    chk("reset.ref", out_order_ref, 64'd0);
    rst = 1'b1;
    tick();
    // single add on ch0: out_valid two cycles after parsed_valid
    out_ready = 1'b1;
    mk_add(0, 48'h0000_1234_5678, 64'h0123_4567_89AB_CDEF, "S", 32'd100, "AAPL    ", 32'd1500000);
    play(4'b0001);
    chk("add.pv_cycle", 64'(out_valid), 64'd0);
    tick();
    chk("add.hold_cycle", 64'(out_valid), 64'd0);
    tick();
    chk_rec("add", 0, 4'd1, 64'h0123_4567_89AB_CDEF, 1'b1, 32'd100, 32'd1500000, 64'd0,
            48'h0000_1234_5678, "AAPL    ");
    chk("add.level1", 64'(fifo_level), 64'd1);
    tick();
    chk("add.level0", 64'(fifo_level), 64'd0);
    chk("add.empty", 64'(out_valid), 64'd0);
    mk_exe(1, 48'hABCD_0000_0001, 64'h1111_2222_3333_4444, 32'd25, 64'h0000_0000_00C0_FFEE);
    play(4'b0010);
    tick();
    tick();
    chk_rec("exe", 1, 4'd4, 64'h1111_2222_3333_4444, 1'b0, 32'd25, 32'd0, 64'd0,
            48'hABCD_0000_0001, 64'h0000_0000_00C0_FFEE);
    tick();
    // simultaneous completion on all channels, rr from reset
    pulse_reset();
    out_ready = 1'b0;
    for (int c = 0; c < NC; c++) mk_del(c, 48'd100, 64'h100 + 64'(c));
    play(4'b1111);
    repeat (5) tick();
    chk("rr1.level", 64'(fifo_level), 64'd4);
    for (int c = 0; c < NC; c++) begin
      chk("rr1.ch", 64'(out_ch), 64'(c));
      chk("rr1.ref", out_order_ref, 64'h100 + 64'(c));
      pop1();
    end
    mk_del(1, 48'd200, 64'h200);
    play(4'b0010);
    repeat (3) tick();
    chk("rr_single.ch", 64'(out_ch), 64'd1);
    pop1();
    for (int c = 0; c < NC; c++) mk_del(c, 48'd300, 64'h300 + 64'(c));
    play(4'b1111);
    repeat (5) tick();
    chk("rr2.level", 64'(fifo_level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr2.ch", 64'(out_ch), 64'(ord[i]));
      chk("rr2.ref", out_order_ref, 64'h300 + 64'(ord[i]));
      pop1();
    end
    chk("rr2.empty", 64'(fifo_level), 64'd0);
    // backpressure: 8 in FIFO, 9th held, 10th dropped
    for (int r = 0; r < 9; r++) begin
      mk_del(2, 48'd400 + 48'(r), 64'h400 + 64'(r));
      play(4'b0100);
    end
    repeat (3) tick();
    chk("full.level", 64'(fifo_level), 64'd8);
    chk("full.nodrop", 64'(drop_cnt), 64'd0);
    mk_del(2, 48'd409, 64'h409);
    play(4'b0100);
    tick();
    chk("full.drop", 64'(drop_cnt), 64'h0100);
    chk("full.level2", 64'(fifo_level), 64'd8);
    // full FIFO with held record: pop and push on one edge
    chk("pp.head0", out_order_ref, 64'h400);
    pop1();
    chk("pp.level", 64'(fifo_level), 64'd8);
    chk("pp.head1", out_order_ref, 64'h401);
    out_ready = 1'b1;
    for (int r = 1; r < 9; r++) begin
      chk("drain.ref", out_order_ref, 64'h400 + 64'(r));
      tick();
    end
    out_ready = 1'b0;
    chk("drain.level", 64'(fifo_level), 64'd0);
    chk("drain.valid", 64'(out_valid), 64'd0);
    // drop counter saturation on ch3
    for (int r = 0; r < 28; r++) begin
      mk_del(3, 48'd500 + 48'(r), 64'h500 + 64'(r));
      play(4'b1000);
      if (r == 22 || r == 23 || r == 27) begin
        tick();
        chk("sat.drop", 64'(drop_cnt), r == 22 ? 64'hE100 : 64'hF100);
      end
    end
    // reset with partial message and FIFO half full
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    chk("half.level", 64'(fifo_level), 64'd4);
    chk("half.head", out_order_ref, 64'h505);
    mk_add(0, 48'd600, 64'h600, "B", 32'd1, "MSFT    ", 32'd2);
    ml[0] = 10;
    play(4'b0001);
    #2 rst = 1'b0;
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.level", 64'(fifo_level), 64'd0);
    chk("rst.drop", 64'(drop_cnt), 64'd0);
    chk("rst.ref", out_order_ref, 64'd0);
    chk("rst.type", 64'(out_type), 64'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst.no_stale", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    mk_rep(0, 48'h0000_0000_0700, 64'h0000_0000_0000_0701, 64'h0000_0000_0000_0702, 32'd77, 32'd123456);
    play(4'b0001);
    tick();
    tick();
    chk_rec("rep", 0, 4'd5, 64'h701, 1'b0, 32'd77, 32'd123456, 64'h702, 48'h700, 64'd0);
    tick();
    chk("rep.level", 64'(fifo_level), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
